// File: rtl/mem_ctrl_pkg.sv
// Shared opcode constants, controller state encoding and opcode classification helpers
// for the MIPS data-memory controller.
package mem_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_mem_op = 1'b1;
      default: is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_misaligned = off[0];
      OP_LW, OP_SW:         is_misaligned = (off != 2'b00);
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte/halfword lane handling: merges store data into the read word for SB/SH and
// extracts and extends load results from the bus word.
module mem_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  lane_byte_s;
  logic [15:0] lane_half_s;

  // Lane selection, store merge and load extension
  always_comb begin
    merged_o    = wdata_i;
    load_o      = 32'h0000_0000;
    lane_byte_s = rdata_i[{byte_off_i, 3'b000} +: 8];
    lane_half_s = byte_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (opcode_i)
      OP_SB: begin
        merged_o = rdata_i;
        merged_o[{byte_off_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      OP_SH: begin
        if (byte_off_i[1]) begin
          merged_o = {wdata_i[15:0], rdata_i[15:0]};
        end else begin
          merged_o = {rdata_i[31:16], wdata_i[15:0]};
        end
      end
      OP_LB:  load_o = {{24{lane_byte_s[7]}}, lane_byte_s};
      OP_LBU: load_o = {24'h00_0000, lane_byte_s};
      OP_LH:  load_o = {{16{lane_half_s[15]}}, lane_half_s};
      OP_LHU: load_o = {16'h0000, lane_half_s};
      OP_LW:  load_o = rdata_i;
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: accepts one load/store from the core, runs the bus
// transfer (read-modify-write for SB/SH) and returns a one-cycle completion pulse.
module data_mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misaligned,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata,
  input  logic        data_waitrequest
);

  state_e      state_q;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wr_word_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_valid_q;
  logic        misaligned_q;
  logic [31:0] merged_s;
  logic [31:0] load_s;

  mem_lane_unit u_lane (
    .opcode_i   (op_q),
    .byte_off_i (addr_q[1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (data_readdata),
    .merged_o   (merged_s),
    .load_o     (load_s)
  );

  // Controller FSM with request latch and registered response/write data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= 6'h00;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      wr_word_q    <= 32'h0000_0000;
      rsp_rdata_q  <= 32'h0000_0000;
      rsp_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      rsp_valid_q  <= 1'b0;
      misaligned_q <= 1'b0;
      rsp_rdata_q  <= 32'h0000_0000;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && is_mem_op(req_opcode)) begin
            op_q    <= req_opcode;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            if (is_misaligned(req_opcode, req_addr[1:0])) begin
              state_q      <= ST_DONE;
              rsp_valid_q  <= 1'b1;
              misaligned_q <= 1'b1;
            end else if (req_opcode == OP_SW) begin
              state_q   <= ST_WRITE;
              wr_word_q <= req_wdata;
            end else begin
              state_q <= ST_READ;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_READ: begin
          if (!data_waitrequest) begin
            if (is_load(op_q)) begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= load_s;
            end else begin
              state_q   <= ST_WRITE;
              wr_word_q <= merged_s;
            end
          end else begin
            state_q <= ST_READ;
          end
        end
        ST_WRITE: begin
          if (!data_waitrequest) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
          end else begin
            state_q <= ST_WRITE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pipeline freeze: raised as soon as a memory op is presented in IDLE
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_IDLE:            stall = req_valid && is_mem_op(req_opcode);
      ST_READ, ST_WRITE:  stall = 1'b1;
      default:            stall = 1'b0;
    endcase
  end

  assign data_read      = (state_q == ST_READ);
  assign data_write     = (state_q == ST_WRITE);
  assign data_address   = {addr_q[31:2], 2'b00};
  assign data_writedata = wr_word_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: bus slave model with programmable wait
// states, scoreboard queues for bus writes and responses, per-scenario tasks.
module tb_data_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [5:0]  req_opcode;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned;
  logic [31:0] data_address;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata = 32'h0;
  logic        data_waitrequest = 1'b0;

  logic [31:0] mem [0:1023];
  int wait_rd_cfg = 0, wait_wr_cfg = 0, rd_cnt = 0, wr_cnt = 0, strobe_cycles = 0;
  int checks = 0, errors = 0;
  logic [32:0] rsp_q [$];
  logic [63:0] wr_q [$];

  always #5 clk = ~clk;

  data_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .misaligned(misaligned), .data_address(data_address),
    .data_read(data_read), .data_write(data_write), .data_writedata(data_writedata),
    .data_readdata(data_readdata), .data_waitrequest(data_waitrequest)
  );

  // Bus slave model plus write/response scoreboard, evaluated away from the clock edge
  always @(negedge clk) begin
    logic [32:0] er;
    logic [63:0] ew;
    if (data_read === 1'b1 && data_write === 1'b1) begin
      checks++; errors++;
      $display("FAIL strobes: data_read and data_write both high at %0t", $time);
    end
    data_readdata = mem[data_address[11:2]];
    if (data_read === 1'b1) data_waitrequest = (rd_cnt < wait_rd_cfg);
    else if (data_write === 1'b1) data_waitrequest = (wr_cnt < wait_wr_cfg);
    else data_waitrequest = 1'b0;
    if (data_read === 1'b1 || data_write === 1'b1) strobe_cycles++;
    if (data_read === 1'b1 && data_waitrequest) rd_cnt++;
    if (data_write === 1'b1 && data_waitrequest) wr_cnt++;
    if (data_read !== 1'b1 && data_write !== 1'b1) begin
      rd_cnt = 0; wr_cnt = 0;
    end
    if (data_write === 1'b1 && !data_waitrequest) begin
      mem[data_address[11:2]] = data_writedata;
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL bus_write: unexpected write addr=%h data=%h", data_address, data_writedata);
      end else begin
        ew = wr_q.pop_front();
        if ({data_address, data_writedata} !== ew) begin
          errors++;
          $display("FAIL bus_write: got addr=%h data=%h expected addr=%h data=%h",
                   data_address, data_writedata, ew[63:32], ew[31:0]);
        end
      end
    end
    if (rsp_valid === 1'b1) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL response: unexpected rsp_valid at %0t", $time);
      end else begin
        er = rsp_q.pop_front();
        if ({misaligned, rsp_rdata} !== er) begin
          errors++;
          $display("FAIL response: got mis=%b rdata=%h expected mis=%b rdata=%h",
                   misaligned, rsp_rdata, er[32], er[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
    logic [31:0] b, h;
    b = (word >> (addr[1:0] * 8)) & 32'h0000_00FF;
    h = (word >> (addr[1] * 16)) & 32'h0000_FFFF;
    case (op)
      OP_LB:   model_load = (b[7] ? 32'hFFFF_FF00 : 32'h0) | b;
      OP_LBU:  model_load = b;
      OP_LH:   model_load = (h[15] ? 32'hFFFF_0000 : 32'h0) | h;
      OP_LHU:  model_load = h;
      OP_LW:   model_load = word;
      default: model_load = 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [5:0] op, input logic [31:0] addr,
                                              input logic [31:0] wd, input logic [31:0] word);
    logic [31:0] m;
    case (op)
      OP_SB: begin
        m = 32'h0000_00FF << (addr[1:0] * 8);
        model_store = (word & ~m) | ((wd & 32'h0000_00FF) << (addr[1:0] * 8));
      end
      OP_SH: begin
        m = 32'h0000_FFFF << (addr[1] * 16);
        model_store = (word & ~m) | ((wd & 32'h0000_FFFF) << (addr[1] * 16));
      end
      default: model_store = wd;
    endcase
  endfunction

  task automatic run_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int rdw, input int wrw, input logic [31:0] exp_rdata,
                         input logic exp_mis, input logic exp_wr, input logic [31:0] exp_word,
                         input int exp_lat, input string name);
    int n, s0;
    wait_rd_cfg = rdw;
    wait_wr_cfg = wrw;
    rsp_q.push_back({exp_mis, exp_rdata});
    if (exp_wr) wr_q.push_back({addr & 32'hFFFF_FFFC, exp_word});
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = op; req_addr = addr; req_wdata = wd;
    s0 = strobe_cycles;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL %s stall_accept: got %b expected 1", name, stall);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wd; req_opcode = OP_SW;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid !== 1'b1 && n < 20);
    checks++;
    if (n != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d expected %0d", name, n, exp_lat);
    end
    if (exp_mis) begin
      checks++;
      if (strobe_cycles != s0) begin
        errors++; $display("FAIL %s no_strobe: got %0d strobe cycles expected 0", name, strobe_cycles - s0);
      end
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || stall !== 1'b0 || misaligned !== 1'b0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL %s after_done: got rv=%b st=%b mis=%b rd=%h expected all 0",
               name, rsp_valid, stall, misaligned, rsp_rdata);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_opcode = 6'h00; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({stall, rsp_valid, misaligned, data_read, data_write} !== 5'b00000 ||
        rsp_rdata !== 32'h0 || data_writedata !== 32'h0 || data_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: st=%b rv=%b mis=%b rd=%b wr=%b rdata=%h wdata=%h addr=%h expected zero",
               stall, rsp_valid, misaligned, data_read, data_write, rsp_rdata, data_writedata, data_address);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_nonmem();
    int s0;
    s0 = strobe_cycles;
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = 6'h00; req_addr = 32'h100;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL nonmem_stall: got %b expected 0", stall);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_opcode = OP_LW;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || strobe_cycles != s0) begin
      errors++; $display("FAIL nonmem_idle: got stall=%b strobes=%0d expected 0 and 0", stall, strobe_cycles - s0);
    end
  endtask

  task automatic test_spec_vectors();
    mem[10'h040] = 32'h1122_3344;
    run_req(OP_SB, 32'h103, 32'h0000_00AB, 0, 0, 32'h0, 1'b0, 1'b1, 32'hAB22_3344, 3, "sb_merge");
    mem[10'h080] = 32'h1122_3344;
    run_req(OP_SH, 32'h202, 32'h0000_BEEF, 2, 0, 32'h0, 1'b0, 1'b1, 32'hBEEF_3344, 5, "sh_wait");
    mem[10'h0C0] = 32'h0000_80FF;
    run_req(OP_LB, 32'h301, 32'h0, 0, 0, 32'hFFFF_FF80, 1'b0, 1'b0, 32'h0, 2, "lb_sext");
    run_req(OP_LBU, 32'h301, 32'h0, 0, 0, 32'h0000_0080, 1'b0, 1'b0, 32'h0, 2, "lbu_zext");
    run_req(OP_LW, 32'h402, 32'h0, 0, 0, 32'h0, 1'b1, 1'b0, 32'h0, 1, "lw_misaligned");
    run_req(OP_SW, 32'h0F0, 32'hCAFE_F00D, 0, 1, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 3, "sw_wait");
    run_req(OP_LH, 32'h0F2, 32'h0, 1, 0, 32'hFFFF_CAFE, 1'b0, 1'b0, 32'h0, 3, "lh_after_sw");
  endtask

  task automatic test_reset_mid_write();
    int n;
    wait_wr_cfg = 10;
    mem[10'h140] = 32'h5555_AAAA;
    @(posedge clk); #1;
    req_valid = 1'b1; req_opcode = OP_SW; req_addr = 32'h500; req_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (data_write !== 1'b1 && n < 10);
    checks++;
    if (data_write !== 1'b1) begin
      errors++; $display("FAIL rst_write_start: got data_write=%b expected 1", data_write);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (data_write !== 1'b0 || stall !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_write: got wr=%b st=%b rv=%b expected 0 0 0", data_write, stall, rsp_valid);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || data_write !== 1'b0) begin
        errors++; $display("FAIL rst_quiet: got rv=%b wr=%b expected 0 0", rsp_valid, data_write);
      end
    end
    checks++;
    if (mem[10'h140] !== 32'h5555_AAAA) begin
      errors++; $display("FAIL rst_mem_untouched: got %h expected 5555aaaa", mem[10'h140]);
    end
    wait_wr_cfg = 0;
  endtask

  task automatic test_random();
    logic [5:0]  ops [8];
    logic [5:0]  op;
    logic [31:0] addr, wd, word, exp_rd, exp_w;
    logic [9:0]  idx;
    logic        mis, ld, wr;
    int          rdw, wrw, lat;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    for (int i = 0; i < 16; i++) begin
      op   = ops[$urandom_range(0, 7)];
      idx  = 10'($urandom_range(0, 1023));
      addr = {20'h0, idx, 2'($urandom_range(0, 3))};
      wd   = $urandom;
      word = $urandom;
      mem[idx] = word;
      rdw  = $urandom_range(0, 2);
      wrw  = $urandom_range(0, 2);
      ld   = (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU);
      mis  = ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]) ||
             ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00);
      wr   = !ld && !mis;
      exp_rd = (ld && !mis) ? model_load(op, addr, word) : 32'h0;
      exp_w  = model_store(op, addr, wd, word);
      if (mis) lat = 1;
      else if (ld) lat = 2 + rdw;
      else if (op == OP_SW) lat = 2 + wrw;
      else lat = 3 + rdw + wrw;
      run_req(op, addr, wd, rdw, wrw, exp_rd, mis, wr, exp_w, lat, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_nonmem();
    test_spec_vectors();
    test_random();
    test_reset_mid_write();
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d responses and %0d writes pending expected 0 and 0",
               rsp_q.size(), wr_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameters: none; opcode constants and state encoding SHALL come from the shared package.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  core presents a memory instruction; held stable while stall=1.
REQ-005 req_opcode  in  6  MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2b.
REQ-006 req_addr  in  32  effective byte address.
REQ-007 req_wdata  in  32  rt contents for stores.
REQ-008 stall  out  1  freezes core pipeline.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_rdata  out  32  extended load result, valid with rsp_valid.
REQ-011 misaligned  out  1  address-error flag, valid with rsp_valid.
REQ-012 data_address  out  32  word-aligned bus address ({req_addr[31:2],2'b00}).
REQ-013 data_read / data_write  out  1 each  bus strobes, never both high.
REQ-014 data_writedata  out  32  bus write word.
REQ-015 data_readdata  in  32  bus read word, valid when data_read=1 and data_waitrequest=0.
REQ-016 data_waitrequest  in  1  bus stall; a transfer completes in a cycle with strobe=1 and waitrequest=0.

Function
REQ-017 States SHALL be IDLE, READ, WRITE, DONE.
REQ-018 IDLE: req_valid with a memory opcode SHALL be accepted; non-memory opcodes or req_valid=0 SHALL leave state IDLE and stall=0.
REQ-019 Accepted request SHALL be latched (opcode, addr, wdata) at acceptance; later input changes SHALL be ignored until DONE.
REQ-020 Misalignment (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) SHALL go IDLE->DONE with no bus strobe and misaligned=1.
REQ-021 Aligned loads and SB/SH SHALL go IDLE->READ; SW SHALL go IDLE->WRITE.
REQ-022 READ: data_read=1 until waitrequest=0; readdata SHALL be captured that cycle; loads ->DONE, SB/SH ->WRITE.
REQ-023 WRITE: data_write=1 with stable data_writedata until waitrequest=0, then ->DONE.
REQ-024 SB merge: lane addr[1:0]=0 ->bits[7:0], 1 ->[15:8], 2 ->[23:16], 3 ->[31:24] replaced by req_wdata[7:0]; other bytes from captured read word.
REQ-025 SH merge: addr[1]=0 ->bits[15:0], 1 ->[31:16] replaced by req_wdata[15:0]; SW writes req_wdata unchanged.
REQ-026 Loads: same lane selection; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word; rsp_rdata registered.
REQ-027 stall SHALL be 1 combinationally in IDLE when an accepted opcode is present, and in READ and WRITE; 0 in DONE.
REQ-028 DONE: rsp_valid=1 for exactly one cycle, then ->IDLE unconditionally; req_valid in DONE SHALL be ignored.
REQ-029 Minimum latency (acceptance cycle to rsp_valid): SW/loads 2 cycles, SB/SH 3 cycles, misaligned 1 cycle; each waitrequest cycle adds one.
REQ-030 Outside their states, data_read, data_write, rsp_valid, misaligned SHALL be 0; rsp_rdata SHALL be 0 for stores and misaligned accesses.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE and zero all registered outputs (rsp_valid, rsp_rdata, misaligned, data_writedata, latched request) by the next cycle.
REQ-032 Reset mid-READ/WRITE SHALL abandon the transfer; strobes SHALL be 0 the cycle after reset; reset has priority over every transition.

Structure
REQ-033 Shared package mem_ctrl_pkg SHALL hold opcode constants and the state enum.
REQ-034 Lane merge and load extension SHALL be one combinational sub-module, mem_lane_unit.
REQ-035 FSM, request latch, and bus strobes SHALL reside in data_mem_ctrl.

Verification
REQ-036 SB addr 0x103, wdata 0xAB, memory word 0x11223344, no waitrequest -> write 0xAB223344 to 0x100, rsp_valid 3 cycles after acceptance.
REQ-037 SH addr 0x202, wdata 0xBEEF, word 0x11223344, waitrequest high 2 cycles on read -> write 0xBEEF3344, rsp_valid at cycle 5.
REQ-038 LB addr 0x301, word 0x000080FF -> rsp_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 LW addr 0x402 -> no strobe, rsp_valid and misaligned=1 at cycle 1, stall low thereafter.
REQ-040 reset asserted during WRITE of SW -> data_write=0 next cycle, state IDLE, stall=0, no rsp_valid.
